// File: rtl/serial_tx.sv
// Serial transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Every bit is held for CLKS_PER_BIT clocks and the line is driven straight from a flop.
module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);

    state_t     state;
    logic [7:0] bit_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic       parity_bit;
    logic       bit_end;

    assign bit_end = (bit_cnt == LAST_TICK);
    assign tx_busy = ~tx_ready;

    // The value for the next bit is loaded into tx_line on the last tick of the current bit,
    // so every bit boundary coincides with a bit-counter wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_line    <= 1'b1;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift_reg  <= tx_data;
                        parity_bit <= ^tx_data;
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        tx_line    <= 1'b0;
                        tx_ready   <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx_line <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                tx_line <= parity_bit;
                                state   <= PARITY;
                            end else begin
                                tx_line <= 1'b1;
                                state   <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_line   <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx_line <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt  <= '0;
                        tx_ready <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                default: begin
                    tx_line  <= 1'b1;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: three instances (4 clk/bit, 4 clk/bit + parity, 2 clk/bit)
// with a per-lane monitor that rebuilds each expected frame from the accepted byte.
module tb_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data  [3];
    logic       tx_valid [3];
    logic       rdy      [3];
    logic       line     [3];
    logic       busy     [3];
    logic       done     [3];

    int checks   = 0;
    int failures = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        case (i)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic pop_exp(input int i, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = 8'h00;
        case (i)
            0: if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin d = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Frame bit b of a byte: 0 = start, 1..8 = data LSB first, then parity (if any), then stop.
    function automatic logic frame_bit(input logic [7:0] d, input int b, input int p);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && p != 0) return ^d;
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int C = (g == 2) ? 2 : 4;
        localparam int P = (g == 1) ? 1 : 0;

        serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(P)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .tx_data  (tx_data[g]),
            .tx_valid (tx_valid[g]),
            .tx_ready (rdy[g]),
            .tx_line  (line[g]),
            .tx_busy  (busy[g]),
            .tx_done  (done[g])
        );

        initial begin : monitor
            logic [7:0] d;
            bit         ok;
            bit         aborted;
            forever begin
                @(negedge clk);
                if (rst_n && line[g] == 1'b0) begin
                    pop_exp(g, d, ok);
                    if (!ok) begin
                        chk($sformatf("lane%0d_unexpected_start", g), 1, 0);
                        while (rst_n && line[g] == 1'b0) @(negedge clk);
                    end else begin
                        aborted = 1'b0;
                        for (int k = 0; k < (10 + P) * C; k++) begin
                            if (k > 0) @(negedge clk);
                            if (!rst_n) begin
                                aborted = 1'b1;
                                break;
                            end
                            chk($sformatf("lane%0d_byte%02h_cyc%0d_line", g, d, k),
                                int'(line[g]), int'(frame_bit(d, k / C, P)));
                            chk($sformatf("lane%0d_cyc%0d_done_low", g, k), int'(done[g]), 0);
                        end
                        if (!aborted) begin
                            @(negedge clk);
                            if (rst_n) begin
                                chk($sformatf("lane%0d_byte%02h_done", g, d), int'(done[g]), 1);
                                chk($sformatf("lane%0d_ready_with_done", g), int'(rdy[g]), 1);
                            end
                        end
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the first start-bit cycle.
    task automatic send(input int i, input logic [7:0] d, input bit hold, output int waited);
        waited        = 0;
        tx_data[i]    = d;
        tx_valid[i]   = 1'b1;
        while (!rdy[i] && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy[i]) begin
            chk($sformatf("lane%0d_accept_timeout", i), 0, 1);
            tx_valid[i] = 1'b0;
        end else begin
            push_exp(i, d);
            @(negedge clk);
            if (!hold) tx_valid[i] = 1'b0;
            chk($sformatf("lane%0d_start_after_accept", i), int'(line[i]), 0);
            chk($sformatf("lane%0d_busy_after_accept", i), int'(busy[i]), 1);
        end
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (!rdy[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[i]) chk($sformatf("lane%0d_idle_timeout", i), 0, 1);
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        int         w;
        int         n;
        int         hits;
        logic [7:0] d;
        bit         hold;

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lane%0d_reset_line", i), int'(line[i]), 1);
            chk($sformatf("lane%0d_reset_ready", i), int'(rdy[i]), 1);
            chk($sformatf("lane%0d_reset_busy", i), int'(busy[i]), 0);
            chk($sformatf("lane%0d_reset_done", i), int'(done[i]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(0, 8'hA5, 1'b0, w);
        chk("first_accept_wait", w, 0);
        wait_idle(0);

        send(1, 8'h07, 1'b0, w);
        wait_idle(1);
        send(1, 8'h03, 1'b0, w);
        wait_idle(1);
        send(2, 8'h80, 1'b0, w);
        wait_idle(2);

        send(0, 8'h00, 1'b1, w);
        send(0, 8'hFF, 1'b0, w);
        chk("b2b_ready_wait", w, 40);
        wait_idle(0);

        send(0, 8'h3C, 1'b0, w);
        n    = 0;
        hits = 0;
        while (busy[0] && n < 100) begin
            tx_data[0]  = 8'($urandom);
            tx_valid[0] = 1'($urandom_range(0, 1));
            if (rdy[0]) hits++;
            @(negedge clk);
            n++;
        end
        tx_valid[0] = 1'b0;
        chk("busy_ready_cycles", hits, 0);
        chk("busy_frame_len", n, 40);
        wait_idle(0);

        send(0, 8'hB6, 1'b0, w);
        repeat (4 * 4 + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_line", int'(line[0]), 1);
        chk("midreset_busy", int'(busy[0]), 0);
        chk("midreset_ready", int'(rdy[0]), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hits  = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (line[0] == 1'b0) hits++;
        end
        chk("midreset_no_zero", hits, 0);

        for (int i = 0; i < 3; i++) begin
            for (int f = 0; f < 8; f++) begin
                d    = 8'($urandom);
                hold = (f == 7) ? 1'b0 : 1'($urandom_range(0, 1));
                send(i, d, hold, w);
                if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(i);
        end
    endtask

    task automatic checkOutput();
        repeat (10) @(negedge clk);
        chk("lane0_queue_drained", q0.size(), 0);
        chk("lane1_queue_drained", q1.size(), 0);
        chk("lane2_queue_drained", q2.size(), 0);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
